menu_key_ctrl: RTL

- Front end of the menu sound path; sits directly upstream of the jingle/beep generator.
- Synchronises and debounces five raw active-low push buttons.
- Emits one-cycle key-press pulses on a 5-bit key bus.
- Maintains the menu cursor (select_flag) that the beep stage samples after an OK press.
- Applies an OK lockout so the confirm jingle is not retriggered while it plays.

---
 rtl/menu_key_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/menu_key_ctrl.sv
// menu_key_ctrl: front end of the menu sound path.
// Synchronises and debounces five active-low push buttons, emits one-cycle
// press pulses, maintains the menu cursor and blocks all key pulses for a
// fixed time after an OK press so the confirm jingle is not retriggered.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active-HIGH despite the legacy name
//   key_in[4:0]  raw buttons, active-low, asynchronous
//                (bit0 UP, bit1 DOWN, bit2 LEFT, bit3 RIGHT, bit4 OK)
//   key[4:0]     registered one-cycle active-high press pulses, same mapping
//   select_flag  menu cursor, 0..NUM_ITEMS-1, updated with the key pulse
//   lock         high while the OK lockout is running
module menu_key_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LOCK_CYC     = 15_000_000,
  parameter int NUM_ITEMS    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key_in,
  output logic [4:0] key,
  output logic [1:0] select_flag,
  output logic       lock
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int LCK_W = $clog2(LOCK_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'(LOCK_CYC - 1);
  localparam logic [1:0]       SEL_MAX  = 2'(NUM_ITEMS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_t;

  logic [4:0]       sync_p0;
  logic [4:0]       sync_p1;
  db_state_t        state     [5];
  db_state_t        state_nxt [5];
  logic [CNT_W-1:0] cnt       [5];
  logic [CNT_W-1:0] cnt_nxt   [5];
  logic [4:0]       press_det;
  logic [4:0]       key_nxt;
  logic [1:0]       sel_nxt;
  logic [LCK_W-1:0] lock_cnt;

  // ---- stage p0/p1: two-flop synchroniser, preset to released ----
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= key_in;
      sync_p1 <= sync_p0;
    end
  end

  // ---- debounce FSMs: one per button, each with its own counter ----
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 5; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    press_det = '0;
    for (int i = 0; i < 5; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        IDLE: begin
          if (!sync_p1[i]) begin
            cnt_nxt[i]   = '0;
            state_nxt[i] = PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (sync_p1[i]) begin
            state_nxt[i] = IDLE;
          end else if (cnt[i] == CNT_LAST) begin
            // Single pulse on acceptance; HELD never re-fires, so no repeat.
            press_det[i] = 1'b1;
            state_nxt[i] = HELD;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        HELD: begin
          if (sync_p1[i]) begin
            cnt_nxt[i]   = '0;
            state_nxt[i] = RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (!sync_p1[i]) begin
            state_nxt[i] = HELD;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = IDLE;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // ---- output stage: gated pulses, cursor and lockout share one edge ----
  // Pulses detected while locked are dropped outright, never queued.
  assign key_nxt = press_det & ~{5{lock}};

  always_comb begin
    sel_nxt = select_flag;
    if (key_nxt[0] && !key_nxt[1]) begin
      sel_nxt = (select_flag == 2'd0) ? SEL_MAX : select_flag - 2'd1;
    end else if (key_nxt[1] && !key_nxt[0]) begin
      sel_nxt = (select_flag == SEL_MAX) ? 2'd0 : select_flag + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      key         <= '0;
      select_flag <= '0;
      lock        <= 1'b0;
      lock_cnt    <= '0;
    end else begin
      key         <= key_nxt;
      select_flag <= sel_nxt;
      // Loading LOCK_CYC-1 and clearing on the edge that sees zero keeps
      // lock high for exactly LOCK_CYC cycles.
      if (key_nxt[4]) begin
        lock     <= 1'b1;
        lock_cnt <= LCK_LOAD;
      end else if (lock) begin
        if (lock_cnt == '0) begin
          lock <= 1'b0;
        end else begin
          lock_cnt <= lock_cnt - LCK_W'(1);
        end
      end
    end
  end

endmodule
